// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a - b through one full_subtractor cell and a borrow flop.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    // Handshake: start is sampled only while busy=0; the operation then runs with
    // busy=1 until done pulses for one cycle, after which diff/borrow stay valid
    // until the next accepted start.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, diff_q;
    logic [CW-1:0]    cnt;
    logic             bin_q, borrow_q;
    logic             d_bit, bout_bit;
    logic             last_bit;

    full_subtractor u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb, ovf_q;
    assign overflow = ovf_q;
`endif

    // Each result bit enters at the MSB, so the first (LSB) bit reaches bit 0 after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        diff_q   <= '0;
                        cnt      <= '0;
                        bin_q    <= 1'b0;
                        borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        ovf_q    <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                    bin_q  <= bout_bit;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        borrow_q <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q    <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corners, random operands,
// held-start throughput and asynchronous reset mid-operation.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow;
    logic [W-1:0] diff;
    logic         overflow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign overflow = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, packed as {overflow, borrow, diff}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned ux, uy;
        int sx, sy, sd;
        logic [W-1:0] d;
        logic br, ov;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        sd = sx - sy;
        d  = W'(ux - uy);
        br = (ux < uy);
        ov = (sd < -(2 ** (W - 1))) || (sd > (2 ** (W - 1)) - 1);
`ifndef SERIAL_SUB_OVF_EN
        ov = 1'b0;
`endif
        return {ov, br, d};
    endfunction

    // Scoreboard: expected results and accept cycles, pushed on accept, popped on done.
    logic [W+1:0] exp_q[$];
    int           acc_q[$];
    int           cyc = 0;
    int           res_cnt = 0;
    int           last_acc = -1;
    bit           hold_mode = 1'b0;
    logic         done_prev = 1'b0;

    always @(negedge clk) begin
        logic [W+1:0] e;
        int c0;
        cyc++;
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (done) begin
                check("done_pulse_width", done_prev, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    e  = exp_q.pop_front();
                    c0 = acc_q.pop_front();
                    check("latency", cyc - c0, W + 1);
                    check("diff", diff, e[W-1:0]);
                    check("borrow", borrow, e[W]);
`ifdef SERIAL_SUB_OVF_EN
                    check("overflow", overflow, e[W+1]);
`endif
                end
                res_cnt++;
            end
            if (start && !busy) begin
                if (hold_mode && last_acc >= 0) check("accept_gap", cyc - last_acc, W + 2);
                last_acc = cyc;
                exp_q.push_back(model(a, b));
                acc_q.push_back(cyc);
            end
            done_prev = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_result(input int r0);
        int n = 0;
        while (res_cnt == r0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (res_cnt == r0) check("done_timeout", res_cnt, r0 + 1);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
        int r0;
        logic [W+1:0] e;
        wait_idle();
        r0 = res_cnt;
        e  = model(x, y);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        wait_result(r0);
        a = W'($urandom);
        b = W'($urandom);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("diff_hold", diff, e[W-1:0]);
        check("borrow_hold", borrow, e[W]);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);

        do_op(8'd5, 8'd3);
        do_op(8'd3, 8'd5);
        do_op(8'd0, 8'd0);
        do_op(8'h80, 8'h01);
        do_op(8'h7F, 8'hFF);
        do_op(8'hFF, 8'h00);
        do_op(8'h00, 8'hFF);
        for (int i = 0; i < 20; i++) do_op(W'($urandom), W'($urandom_range(0, 255)));

        // Start held high: back-to-back accepts, operands scrambled mid-operation.
        wait_idle();
        hold_mode = 1'b1;
        last_acc  = -1;
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int r0;
            int n;
            r0 = res_cnt;
            n  = 0;
            while (!busy && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("hold_busy", busy, 1);
            a = W'($urandom);
            b = W'($urandom);
            repeat (4) begin
                @(posedge clk); #1;
            end
            a = 8'hFF;
            b = 8'hFF;
            wait_result(r0);
        end
        start = 1'b0;
        wait_idle();
        hold_mode = 1'b0;
        check("hold_diff", diff, 8'h00);
        check("hold_borrow", borrow, 0);

        // Asynchronous reset four cycles into an operation.
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("partial_diff", diff, 8'hF0);
        check("partial_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_diff", diff, 0);
        check("async_rst_borrow", borrow, 0);
        check("async_rst_overflow", overflow, 0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(8'd10, 8'd4);
        check("after_rst_diff", diff, 8'h06);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
